// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: once per frame, move the bouncing ball one step on X and then on Y.
// The four direction buttons are synchronised, debounced and arbitrated to steer the ball.
// Build option BALL_AUTO_BOUNCE_EN:
//   defined   - the ball bounces on its own and reflects at the edges; buttons only steer.
//   undefined - manual mode: an axis moves only while one of its buttons is held, and
//               the ball clamps at the edges.
//
// state   | meaning
// IDLE    | wait for frame_tick
// MOVE_X  | compute next X, apply any X reflection
// MOVE_Y  | compute next Y, apply any Y reflection, load both positions
// COMMIT  | new position visible, pos_update high
module ball_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 16,
    parameter int STEP      = 2,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       pos_update
);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;

`ifdef BALL_AUTO_BOUNCE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam int               CW     = $clog2(DB_CYCLES + 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]       X_RST  = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]       Y_RST  = 10'((V_ACTIVE - BALL_SIZE) / 2);

    // Button bit order: 3 = up, 2 = down, 1 = left, 0 = right.
    logic [3:0]    btn_raw, sync_a, sync_b, btn_db;
    logic [CW-1:0] db_cnt [4];

    state_t      state, state_nxt;
    logic        dir_x_nxt, dir_y_nxt;
    logic        x_pos, x_neg, y_pos, y_neg;
    logic [10:0] x_step, y_step;
    logic [9:0]  nx_r;

    assign btn_raw = {up, down, left, right};

    // Returns {edge_hit, new_position}; saturates at 0 and lim, never leaves the legal range.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic go_pos,
                                              input logic go_neg, input logic signed [10:0] lim);
        logic signed [10:0] p;
        logic [10:0]        r;
        p = signed'({1'b0, pos});
        r = {1'b0, pos};
        if (go_pos) begin
            if (p + STEP_S >= lim) r = {1'b1, lim[9:0]};
            else                   r = {1'b0, 10'(p + STEP_S)};
        end else if (go_neg) begin
            if (p <= STEP_S) r = {1'b1, 10'd0};
            else             r = {1'b0, 10'(p - STEP_S)};
        end
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: a new level is accepted after it has differed from the current one for DB_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    btn_db[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Per-axis motion request and the candidate next positions.
    always_comb begin
        if (AUTO_EN) begin
            x_pos = dir_x;
            x_neg = ~dir_x;
            y_pos = dir_y;
            y_neg = ~dir_y;
        end else begin
            x_pos = btn_db[0] & ~btn_db[1];
            x_neg = btn_db[1] & ~btn_db[0];
            y_pos = btn_db[2] & ~btn_db[3];
            y_neg = btn_db[3] & ~btn_db[2];
        end
        x_step = axis_step(ball_x, x_pos, x_neg, X_MAX);
        y_step = axis_step(ball_y, y_pos, y_neg, Y_MAX);
    end

    // Next state, button arbitration of direction, and edge reflection (reflection wins).
    always_comb begin
        state_nxt = state;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        case (state)
            IDLE:    if (frame_tick) state_nxt = MOVE_X;
            MOVE_X:  state_nxt = MOVE_Y;
            MOVE_Y:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (btn_db[1] & ~btn_db[0])      dir_x_nxt = 1'b0;
        else if (btn_db[0] & ~btn_db[1]) dir_x_nxt = 1'b1;
        if (btn_db[3] & ~btn_db[2])      dir_y_nxt = 1'b0;
        else if (btn_db[2] & ~btn_db[3]) dir_y_nxt = 1'b1;
        if (AUTO_EN && state == MOVE_X && x_step[10]) dir_x_nxt = ~dir_x;
        if (AUTO_EN && state == MOVE_Y && y_step[10]) dir_y_nxt = ~dir_y;
    end

    // State and direction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else begin
            state <= state_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
        end
    end

    // Position registers: both axes load together so they become visible in COMMIT with the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nx_r       <= X_RST;
            ball_x     <= X_RST;
            ball_y     <= Y_RST;
            pos_update <= 1'b0;
        end else begin
            pos_update <= (state == MOVE_Y);
            if (state == MOVE_X) nx_r <= x_step[9:0];
            if (state == MOVE_Y) begin
                ball_x <= nx_r;
                ball_y <= y_step[9:0];
            end
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with a short debounce (DB_CYCLES = 4).
// Expected positions are hand-computed for whichever build option is selected.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, pos_update;

    int         n_vec = 0;
    int         n_err = 0;
    int         p_at, p_cnt;
    logic [9:0] r_x, r_y;

    ball_motion_ctrl #(.DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(up), .down(down), .left(left), .right(right),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .pos_update(pos_update)
    );

    always #10 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // frame_tick high for 'hold' cycles, optional reset assertion 'rst_at' negedges later;
    // records the first pos_update pulse position (in negedges after the tick) and the ball there.
    task automatic run_tick(input int hold, input int rst_at);
        p_at  = -1;
        p_cnt = 0;
        r_x   = '0;
        r_y   = '0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == hold) frame_tick = 1'b0;
            if (i == rst_at) reset = 1'b0;
            #1;
            if (pos_update) begin
                p_cnt++;
                if (p_at < 0) begin
                    p_at = i;
                    r_x  = ball_x;
                    r_y  = ball_y;
                end
            end
        end
    endtask

    initial begin
        wait_cyc(3);
        chk_val("rst_x", ball_x, 312);
        chk_val("rst_y", ball_y, 232);
        chk_val("rst_dir_x", dir_x, 1);
        chk_val("rst_dir_y", dir_y, 1);
        chk_val("rst_pulse", pos_update, 0);
        reset = 1'b1;
        wait_cyc(3);

`ifdef BALL_AUTO_BOUNCE_EN
        run_tick(1, 0);
        chk_val("t1_lat", p_at, 3);
        chk_val("t1_x", r_x, 314);
        chk_val("t1_y", r_y, 234);
        run_tick(1, 0);
        chk_val("t2_x", r_x, 316);
        chk_val("t2_y", r_y, 236);

        up = 1'b1; wait_cyc(2); up = 1'b0; wait_cyc(10);
        chk_val("up_short", dir_y, 1);
        up = 1'b1; wait_cyc(8);
        chk_val("up_held", dir_y, 0);
        run_tick(1, 0);
        chk_val("up_x", r_x, 318);
        chk_val("up_y", r_y, 234);
        up = 1'b0; wait_cyc(10);
        chk_val("up_rel", dir_y, 0);

        down = 1'b1; wait_cyc(8);
        chk_val("down_held", dir_y, 1);
        up = 1'b1; wait_cyc(10);
        chk_val("both_dir", dir_y, 1);
        for (int k = 1; k <= 3; k++) begin
            run_tick(1, 0);
            chk_val("both_y", r_y, 10'(234 + 2 * k));
            chk_val("both_dy", dir_y, 1);
        end
        up = 1'b0; down = 1'b0; wait_cyc(10);

        run_tick(2, 0);
        chk_val("dbl_cnt", p_cnt, 1);
        chk_val("dbl_lat", p_at, 3);
        chk_val("dbl_x", r_x, 326);
        chk_val("dbl_y", r_y, 242);

        run_tick(1, 2);
        chk_val("mid_rst_pulse", p_cnt, 0);
        chk_val("mid_rst_x", ball_x, 312);
        chk_val("mid_rst_y", ball_y, 232);
        reset = 1'b1;
        wait_cyc(3);

        for (int k = 1; k <= 157; k++) begin
            run_tick(1, 0);
            if (k == 155) begin
                chk_val("edge_x155", r_x, 622);
                chk_val("edge_y155", r_y, 386);
            end
            if (k == 156) begin
                chk_val("edge_x156", r_x, 624);
                chk_val("edge_dx156", dir_x, 0);
                chk_val("edge_y156", r_y, 384);
            end
            if (k == 157) begin
                chk_val("edge_x157", r_x, 622);
                chk_val("edge_y157", r_y, 382);
                chk_val("edge_dy157", dir_y, 0);
            end
        end
`else
        run_tick(1, 0);
        chk_val("t1_lat", p_at, 3);
        chk_val("t1_cnt", p_cnt, 1);
        chk_val("t1_x", r_x, 312);
        chk_val("t1_y", r_y, 232);

        up = 1'b1; wait_cyc(2); up = 1'b0; wait_cyc(10);
        chk_val("up_short", dir_y, 1);
        run_tick(1, 0);
        chk_val("up_short_y", r_y, 232);
        up = 1'b1; wait_cyc(8);
        chk_val("up_held", dir_y, 0);
        run_tick(1, 0);
        chk_val("up_y1", r_y, 230);
        run_tick(1, 0);
        chk_val("up_y2", r_y, 228);
        up = 1'b0; wait_cyc(10);
        chk_val("up_rel_dir", dir_y, 0);
        run_tick(1, 0);
        chk_val("up_rel_y", r_y, 228);

        down = 1'b1; wait_cyc(8);
        chk_val("down_held", dir_y, 1);
        up = 1'b1; wait_cyc(10);
        chk_val("both_dir", dir_y, 1);
        for (int k = 1; k <= 3; k++) begin
            run_tick(1, 0);
            chk_val("both_y", r_y, 228);
            chk_val("both_dy", dir_y, 1);
        end
        up = 1'b0; down = 1'b0; wait_cyc(10);

        right = 1'b1; wait_cyc(8);
        chk_val("right_dir", dir_x, 1);
        for (int k = 1; k <= 158; k++) begin
            run_tick(1, 0);
            if (k == 155) chk_val("right_x155", r_x, 622);
            if (k == 156) chk_val("right_x156", r_x, 624);
            if (k == 158) begin
                chk_val("right_clamp", r_x, 624);
                chk_val("right_clamp_dx", dir_x, 1);
                chk_val("right_clamp_y", r_y, 228);
            end
        end
        right = 1'b0; left = 1'b1; wait_cyc(8);
        chk_val("left_dir", dir_x, 0);
        run_tick(1, 0);
        chk_val("left_x", r_x, 622);

        run_tick(2, 0);
        chk_val("dbl_cnt", p_cnt, 1);
        chk_val("dbl_lat", p_at, 3);
        chk_val("dbl_x", r_x, 620);

        left = 1'b0;
        run_tick(1, 2);
        chk_val("mid_rst_pulse", p_cnt, 0);
        chk_val("mid_rst_x", ball_x, 312);
        chk_val("mid_rst_y", ball_y, 232);
        chk_val("mid_rst_dx", dir_x, 1);
        reset = 1'b1;
        wait_cyc(3);
        run_tick(1, 0);
        chk_val("post_rst_x", r_x, 312);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
